// File: rtl/cq_param.sv
// cq_param: parametrised single-clock circular queue using every one of its 2**ADDR_W slots.
// Latency: a word written at edge N is on dout after edge N; all flags are combinational from the pointers.
// Backpressure: wr on full is dropped unless rd is also asserted in that cycle; rd on empty is dropped.
//
// Ports:
//   clk, reset        sole clock (rising edge); synchronous active-high reset
//   wr, din           write request and data; din is stored when the write is accepted
//   rd                read request; pops the head entry when the queue is non-empty
//   dout              head entry (show-ahead); stale and not valid while empty
//   empty, full       occupancy is 0 / occupancy is DEPTH
//   almost_empty      count <= AE_THRESH
//   almost_full       count >= AF_THRESH
//   count             occupancy, 0..DEPTH
//   ovf, udf          sticky overflow / underflow flags
//
// Optional feature macro: CQ_PARAM_ERR_FLAGS_EN
//   defined   -> ovf/udf latch rejected writes/reads until reset
//   undefined -> ovf/udf tied low (ports kept)
module cq_param #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = (1 << ADDR_W) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds are compared one bit wider than count so a threshold of
  // DEPTH (or anything that fits in ADDR_W+2 bits) behaves arithmetically.
  localparam logic [ADDR_W+1:0] AF_T    = (ADDR_W+2)'(AF_THRESH);
  localparam logic [ADDR_W+1:0] AE_T    = (ADDR_W+2)'(AE_THRESH);
  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  // MSB of each pointer is the wrap bit; the low ADDR_W bits address storage.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;

  // ---------------------------------------------------------------------------
  // Status derived from the pointers
  // ---------------------------------------------------------------------------
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    // Modulo subtraction across the wrap bit yields 0..DEPTH exactly.
    count        = wr_ptr - rd_ptr;
    almost_empty = ({1'b0, count} <= AE_T);
    almost_full  = ({1'b0, count} >= AF_T);
  end

  // A read frees the slot the write needs, so full+rd+wr accepts both.
  // On empty, the read is refused and the write proceeds alone (no bypass).
  always_comb begin
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd);
  end

  assign dout = mem[rd_ptr[ADDR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Pointers and storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared so dout reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[ADDR_W-1:0]] <= din;
        wr_ptr                  <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef CQ_PARAM_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      // A write on full is only an overflow when no read frees a slot.
      if (wr && full && !rd) begin
        ovf_q <= 1'b1;
      end
      if (rd && empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
